// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types and mode encodings for the shift register sequencer.
package shift_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } seq_state_t;

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_RIGHT = 2'b01;
   localparam logic [1:0] MODE_LEFT  = 2'b10;
   localparam logic [1:0] MODE_LOAD  = 2'b11;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Command and datapath bundle of the shift sequencer.
// Optional abort/aborted pair present when SHIFT_SEQ_ABORT_EN is defined.
interface shift_seq_ctrl_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH + 1)
);
   logic             start;
   logic             dir;
   logic             rotate;
   logic [WIDTH-1:0] load_data;
   logic [CNT_W-1:0] shift_cnt;
   logic             ser_in;
   logic [WIDTH-1:0] q_fb;
   logic [1:0]       s;
   logic [WIDTH-1:0] din;
   logic             sin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
`ifdef SHIFT_SEQ_ABORT_EN
   logic             abort;
   logic             aborted;

   modport master (output start, dir, rotate, load_data, shift_cnt, ser_in, q_fb, abort,
                   input  s, din, sin, busy, done, result, aborted);
   modport slave  (input  start, dir, rotate, load_data, shift_cnt, ser_in, q_fb, abort,
                   output s, din, sin, busy, done, result, aborted);
`else
   modport master (output start, dir, rotate, load_data, shift_cnt, ser_in, q_fb,
                   input  s, din, sin, busy, done, result);
   modport slave  (input  start, dir, rotate, load_data, shift_cnt, ser_in, q_fb,
                   output s, din, sin, busy, done, result);
`endif
endinterface

// File: rtl/shift_seq_ctrl_cnt.sv
// Loadable shift-count down-counter; load clamps to WIDTH, flags zero and last.
module shift_seq_cnt #(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] cnt_in,
   input  logic             dec,
   output logic             cnt_zero,
   output logic             cnt_last
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // next count: clamp on load, saturating decrement otherwise
   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = (cnt_in > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cnt_in;
      else if (dec && cnt_q != '0)
         cnt_d = cnt_q - CNT_W'(1);
   end

   // count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt_zero = (cnt_q == '0);
   assign cnt_last = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer for a universal shift register: LOAD, N x SHIFT, DONE per job.
// Config macro: SHIFT_SEQ_ABORT_EN adds abort input / aborted output.
module shift_seq_ctrl
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input logic            clk,
   input logic            rst_n,
   shift_seq_ctrl_if.slave bus
);
   seq_state_t       state_q, state_d;
   logic             dir_q, dir_d, rotate_q, rotate_d;
   logic [WIDTH-1:0] load_data_q, load_data_d, result_q, result_d;
   logic             cnt_zero, cnt_last, job_take, abort_hit;
   logic [1:0]       s_o;
   logic [WIDTH-1:0] din_o;
   logic             sin_o, busy_o, done_o;

   assign job_take = (state_q == IDLE) && bus.start;

`ifdef SHIFT_SEQ_ABORT_EN
   logic aborted_q, aborted_d;

   assign abort_hit = bus.abort && (state_q == LOAD || state_q == SHIFT);

   // aborted is high exactly in the DONE cycle reached through an abort
   always_comb aborted_d = abort_hit;

   // aborted flag register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) aborted_q <= 1'b0;
      else        aborted_q <= aborted_d;
   end

   assign bus.aborted = aborted_q;
`else
   assign abort_hit = 1'b0;
`endif

   shift_seq_cnt #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (job_take),
      .cnt_in   (bus.shift_cnt),
      .dec      (state_q == SHIFT),
      .cnt_zero (cnt_zero),
      .cnt_last (cnt_last)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = LOAD;
         LOAD:    state_d = (abort_hit || cnt_zero) ? DONE : SHIFT;
         SHIFT:   if (abort_hit || cnt_last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // output decode; the register acts on these at the next edge
   always_comb begin
      s_o    = MODE_HOLD;
      din_o  = '0;
      sin_o  = 1'b0;
      busy_o = 1'b0;
      done_o = 1'b0;
      case (state_q)
         LOAD: begin
            busy_o = 1'b1;
            din_o  = load_data_q;
            if (!abort_hit) s_o = MODE_LOAD;
         end
         SHIFT: begin
            busy_o = 1'b1;
            din_o  = bus.q_fb;
            sin_o  = rotate_q ? (dir_q ? bus.q_fb[WIDTH-1] : bus.q_fb[0]) : bus.ser_in;
            if (!abort_hit) s_o = dir_q ? MODE_LEFT : MODE_RIGHT;
         end
         DONE: begin
            busy_o = 1'b1;
            done_o = 1'b1;
         end
         default: ;
      endcase
   end

   // job latches and result capture
   always_comb begin
      dir_d       = dir_q;
      rotate_d    = rotate_q;
      load_data_d = load_data_q;
      result_d    = result_q;
      if (job_take) begin
         dir_d       = bus.dir;
         rotate_d    = bus.rotate;
         load_data_d = bus.load_data;
      end
      if (state_q == DONE) result_d = bus.q_fb;
   end

   // job field and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dir_q       <= 1'b0;
         rotate_q    <= 1'b0;
         load_data_q <= '0;
         result_q    <= '0;
      end else begin
         dir_q       <= dir_d;
         rotate_q    <= rotate_d;
         load_data_q <= load_data_d;
         result_q    <= result_d;
      end
   end

   assign bus.s      = s_o;
   assign bus.din    = din_o;
   assign bus.sin    = sin_o;
   assign bus.busy   = busy_o;
   assign bus.done   = done_o;
   assign bus.result = result_q;
endmodule
